mem_responder: RTL and testbench

- Memory-side responder for the core's three memory ports: i-cache line read, d-cache line read, d-cache line write.
- Sits outside mips_core. It accepts single-address line requests, arbitrates between them, and serves them from an internal word-addressed memory array.
- Reads return LINE_WORDS words after a fixed latency; writes absorb LINE_WORDS data beats.
- Serves one transaction at a time; no outstanding-request queue.

---
 rtl/mem_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: arbitrated line-read / line-write responder in front of a word-addressed array.
// Latency: first read beat READ_LATENCY cycles after acceptance, then LINE_WORDS back-to-back beats;
// backpressure: none on read data; write beats may have gaps; one transaction at a time.
// Optional: define MEM_RESPONDER_RR_EN for round-robin arbitration between the two read ports.
module mem_responder #(
  parameter int ADDR_WIDTH     = 26,
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_WORDS     = 4,
  parameter int MEM_DEPTH_LOG2 = 14,
  parameter int READ_LATENCY   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_rd_req_addr,
  output logic                  i_rd_req_ready,
  output logic                  i_rd_data_valid,
  output logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  d_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] d_rd_req_addr,
  output logic                  d_rd_req_ready,
  output logic                  d_rd_data_valid,
  output logic [DATA_WIDTH-1:0] d_rd_data,
  input  logic                  d_wr_req_valid,
  input  logic [ADDR_WIDTH-1:0] d_wr_req_addr,
  output logic                  d_wr_req_ready,
  input  logic                  d_wr_data_valid,
  input  logic [DATA_WIDTH-1:0] d_wr_data,
  output logic                  d_wr_done
);

  localparam int IDX_W  = MEM_DEPTH_LOG2;
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

  // Clears the word-within-line bits so every burst starts on a line boundary.
  localparam logic [IDX_W-1:0]  LINE_MASK = ~IDX_W'(LINE_WORDS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = (READ_LATENCY > 1) ? WAIT_W'(READ_LATENCY - 2) : WAIT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_BURST,
    ST_WR_DATA
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    base_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                rd_sel_d_q;     // 1: burst belongs to the d-cache read port
  logic                i_vld_q;
  logic                d_vld_q;
  logic [DATA_WIDTH-1:0] i_dat_q;
  logic [DATA_WIDTH-1:0] d_dat_q;
  logic                done_q;

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<IDX_W)-1];

  logic                grant_wr;
  logic                grant_drd;
  logic                grant_ird;
  logic                rd_acc;
  logic                prefer_drd;
  logic [IDX_W-1:0]    acc_base;
  logic [IDX_W-1:0]    wr_base;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    wr_idx;
  logic                wr_en;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                unused_addr;

  // Only the word-index bits of the addresses reach the array; the rest wrap silently.
  assign unused_addr = ^{i_rd_req_addr, d_rd_req_addr, d_wr_req_addr};

  assign acc_base = (grant_drd ? d_rd_req_addr[IDX_W+1:2] : i_rd_req_addr[IDX_W+1:2]) & LINE_MASK;
  assign wr_base  = d_wr_req_addr[IDX_W+1:2] & LINE_MASK;

`ifdef MEM_RESPONDER_RR_EN
  logic prefer_drd_q;

  // Remember which read port lost last time so it wins the next contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefer_drd_q <= 1'b1;
    end else if (grant_drd || grant_ird) begin
      prefer_drd_q <= grant_ird;
    end
  end

  assign prefer_drd = prefer_drd_q;
`else
  assign prefer_drd = 1'b1;
`endif

  // Arbitrate in IDLE only: write first, then the reads; readies are held low during reset.
  always_comb begin
    grant_wr  = 1'b0;
    grant_drd = 1'b0;
    grant_ird = 1'b0;
    if (rst_n && (state_q == ST_IDLE)) begin
      if (d_wr_req_valid) begin
        grant_wr = 1'b1;
      end else if (d_rd_req_valid && (!i_rd_req_valid || prefer_drd)) begin
        grant_drd = 1'b1;
      end else if (i_rd_req_valid) begin
        grant_ird = 1'b1;
      end
    end
  end

  assign rd_acc         = grant_drd || grant_ird;
  assign d_wr_req_ready = grant_wr;
  assign d_rd_req_ready = grant_drd;
  assign i_rd_req_ready = grant_ird;

  // Pick the word that will be registered onto the data bus at the next edge.
  always_comb begin
    rd_idx = acc_base;
    if (state_q == ST_RD_WAIT) begin
      rd_idx = base_q;
    end else if (state_q == ST_RD_BURST) begin
      rd_idx = base_q + IDX_W'(beat_q) + IDX_W'(1);
    end
  end

  assign rd_word = mem_q[rd_idx];
  assign wr_idx  = base_q + IDX_W'(beat_q);
  assign wr_en   = (state_q == ST_WR_DATA) && d_wr_data_valid;

  // Array storage is not reset; a write beat lands only while a write line is open.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= d_wr_data;
    end
  end

  // Transaction FSM with registered data-path outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      beat_q     <= '0;
      wait_q     <= '0;
      rd_sel_d_q <= 1'b0;
      i_vld_q    <= 1'b0;
      d_vld_q    <= 1'b0;
      i_dat_q    <= '0;
      d_dat_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_wr) begin
            base_q  <= wr_base;
            beat_q  <= '0;
            state_q <= ST_WR_DATA;
          end else if (rd_acc) begin
            base_q     <= acc_base;
            beat_q     <= '0;
            wait_q     <= '0;
            rd_sel_d_q <= grant_drd;
            if (READ_LATENCY == 1) begin
              state_q <= ST_RD_BURST;
              i_vld_q <= grant_ird;
              d_vld_q <= grant_drd;
              i_dat_q <= grant_ird ? rd_word : '0;
              d_dat_q <= grant_drd ? rd_word : '0;
            end else begin
              state_q <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (wait_q == LAST_WAIT) begin
            state_q <= ST_RD_BURST;
            i_vld_q <= !rd_sel_d_q;
            d_vld_q <= rd_sel_d_q;
            i_dat_q <= rd_sel_d_q ? '0 : rd_word;
            d_dat_q <= rd_sel_d_q ? rd_word : '0;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_RD_BURST: begin
          if (beat_q == LAST_BEAT) begin
            state_q <= ST_IDLE;
            i_vld_q <= 1'b0;
            d_vld_q <= 1'b0;
            i_dat_q <= '0;
            d_dat_q <= '0;
          end else begin
            beat_q  <= beat_q + BEAT_W'(1);
            i_dat_q <= rd_sel_d_q ? '0 : rd_word;
            d_dat_q <= rd_sel_d_q ? rd_word : '0;
          end
        end
        ST_WR_DATA: begin
          if (d_wr_data_valid) begin
            if (beat_q == LAST_BEAT) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign i_rd_data_valid = i_vld_q;
  assign i_rd_data       = i_dat_q;
  assign d_rd_data_valid = d_vld_q;
  assign d_rd_data       = d_dat_q;
  assign d_wr_done       = done_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder with default parameters.
// Expected read beats come from a bench-side memory model, queued at request acceptance.
// Read-port order checks follow MEM_RESPONDER_RR_EN when the bench is built with it.
module tb_mem_responder;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int RL = 4;
`ifdef MEM_RESPONDER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          i_rd_req_valid;
  logic [AW-1:0] i_rd_req_addr;
  logic          i_rd_req_ready;
  logic          i_rd_data_valid;
  logic [DW-1:0] i_rd_data;
  logic          d_rd_req_valid;
  logic [AW-1:0] d_rd_req_addr;
  logic          d_rd_req_ready;
  logic          d_rd_data_valid;
  logic [DW-1:0] d_rd_data;
  logic          d_wr_req_valid;
  logic [AW-1:0] d_wr_req_addr;
  logic          d_wr_req_ready;
  logic          d_wr_data_valid;
  logic [DW-1:0] d_wr_data;
  logic          d_wr_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit run_mon  = 1'b0;

  logic [31:0] mdl [int];
  logic [31:0] exp_i [$];
  logic [31:0] exp_d [$];

  mem_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_rd_req_valid  (i_rd_req_valid),
    .i_rd_req_addr   (i_rd_req_addr),
    .i_rd_req_ready  (i_rd_req_ready),
    .i_rd_data_valid (i_rd_data_valid),
    .i_rd_data       (i_rd_data),
    .d_rd_req_valid  (d_rd_req_valid),
    .d_rd_req_addr   (d_rd_req_addr),
    .d_rd_req_ready  (d_rd_req_ready),
    .d_rd_data_valid (d_rd_data_valid),
    .d_rd_data       (d_rd_data),
    .d_wr_req_valid  (d_wr_req_valid),
    .d_wr_req_addr   (d_wr_req_addr),
    .d_wr_req_ready  (d_wr_req_ready),
    .d_wr_data_valid (d_wr_data_valid),
    .d_wr_data       (d_wr_data),
    .d_wr_done       (d_wr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line-aligned array index of a byte address, wrapped to a 16K-word array.
  function automatic int line_idx(input int byte_addr);
    int w;
    w = byte_addr / 4;
    w = w - (w % LW);
    return w % 16384;
  endfunction

  task automatic push_line(input bit is_d, input int addr);
    int base;
    base = line_idx(addr);
    for (int k = 0; k < LW; k++) begin
      if (is_d) exp_d.push_back(mdl[base + k]);
      else      exp_i.push_back(mdl[base + k]);
    end
  endtask

  // Read beats are compared against the scoreboard; idle data must be zero.
  always @(negedge clk) begin
    if (run_mon) begin
      if (i_rd_data_valid) begin
        if (exp_i.size() == 0) check("i_rd_unexpected_beat", 32'd1, 32'd0);
        else check("i_rd_data", i_rd_data, exp_i.pop_front());
      end else begin
        check("i_rd_data_idle", i_rd_data, 32'd0);
      end
      if (d_rd_data_valid) begin
        if (exp_d.size() == 0) check("d_rd_unexpected_beat", 32'd1, 32'd0);
        else check("d_rd_data", d_rd_data, exp_d.pop_front());
      end else begin
        check("d_rd_data_idle", d_rd_data, 32'd0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the done pulse.
  task automatic do_write(input int addr, input int npat, input logic [15:0] pat,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] wd [4];
    int base;
    int waited;
    int k;
    bit got;
    wd = '{w0, w1, w2, w3};
    base = line_idx(addr);
    d_wr_req_valid = 1'b1;
    d_wr_req_addr  = addr[AW-1:0];
    got = 1'b0;
    waited = 0;
    while (!got && waited < 200) begin
      #3;
      if (d_wr_req_ready) got = 1'b1;
      else waited++;
      @(posedge clk); #1;
    end
    d_wr_req_valid = 1'b0;
    check("wr_accept", 32'(got), 32'd1);
    if (!got) return;
    k = 0;
    for (int j = 0; j < npat; j++) begin
      d_wr_data_valid = pat[j];
      d_wr_data = pat[j] ? wd[k] : (32'hDEAD_0000 + 32'(j));
      if (pat[j]) begin
        mdl[base + k] = wd[k];
        k++;
      end
      #3;
      check("wr_done_early", 32'(d_wr_done), 32'd0);
      @(posedge clk); #1;
    end
    d_wr_data_valid = 1'b0;
    #3;
    check("wr_done_pulse", 32'(d_wr_done), 32'd1);
    @(posedge clk); #1;
    #3;
    check("wr_done_once", 32'(d_wr_done), 32'd0);
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; checks beat timing and returns after the burst.
  task automatic do_read(input bit is_d, input int addr, output int acc, output int nwait);
    bit got;
    bit v;
    string tag;
    tag = is_d ? "d_rd" : "i_rd";
    got = 1'b0;
    acc = -1;
    nwait = 0;
    if (is_d) begin d_rd_req_valid = 1'b1; d_rd_req_addr = addr[AW-1:0]; end
    else      begin i_rd_req_valid = 1'b1; i_rd_req_addr = addr[AW-1:0]; end
    while (!got && nwait < 200) begin
      #3;
      if (is_d ? d_rd_req_ready : i_rd_req_ready) begin
        got = 1'b1;
        acc = cyc;
        push_line(is_d, addr);
      end else begin
        nwait++;
      end
      @(posedge clk); #1;
    end
    if (is_d) d_rd_req_valid = 1'b0;
    else      i_rd_req_valid = 1'b0;
    check({tag, "_accept"}, 32'(got), 32'd1);
    if (!got) return;
    for (int c = 1; c <= RL + LW; c++) begin
      #3;
      v = is_d ? d_rd_data_valid : i_rd_data_valid;
      check({tag, "_beat_timing"}, 32'(v), 32'((c >= RL) && (c < RL + LW)));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_d, acc_i, nw, nw2, n_acc;
    int t [3];
    bit got;
    t = '{0, 0, 0};

    rst_n = 1'b1;
    i_rd_req_valid = 1'b1; i_rd_req_addr = 26'h40;
    d_rd_req_valid = 1'b1; d_rd_req_addr = 26'h40;
    d_wr_req_valid = 1'b1; d_wr_req_addr = 26'h40;
    d_wr_data_valid = 1'b0; d_wr_data = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_i_rd_req_ready", 32'(i_rd_req_ready), 32'd0);
    check("rst_d_rd_req_ready", 32'(d_rd_req_ready), 32'd0);
    check("rst_d_wr_req_ready", 32'(d_wr_req_ready), 32'd0);
    check("rst_i_rd_data_valid", 32'(i_rd_data_valid), 32'd0);
    check("rst_d_rd_data_valid", 32'(d_rd_data_valid), 32'd0);
    check("rst_i_rd_data", i_rd_data, 32'd0);
    check("rst_d_rd_data", d_rd_data, 32'd0);
    check("rst_d_wr_done", 32'(d_wr_done), 32'd0);
    i_rd_req_valid = 1'b0;
    d_rd_req_valid = 1'b0;
    d_wr_req_valid = 1'b0;
    run_mon = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write a line, then read it back through a mid-line address.
    do_write(32'h40, 4, 16'h000F, 32'h11, 32'h22, 32'h33, 32'h44);
    do_read(1'b1, 32'h48, acc_d, nw);

    // Gapped write beats: valid pattern 1,0,0,1,1,0,1.
    do_write(32'h200, 7, 16'h0059, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
    do_read(1'b1, 32'h200, acc_d, nw);

    // Word index 2^14 wraps onto index 0.
    do_write(32'h10000, 4, 16'h000F, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004);
    do_read(1'b1, 32'h0, acc_d, nw);

    // All three requesters at once: write wins, then the read order.
    fork
      do_write(32'h300, 4, 16'h000F, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
      do_read(1'b1, 32'h40, acc_d, nw);
      do_read(1'b0, 32'h40, acc_i, nw2);
      begin
        #3;
        check("sim_wr_ready", 32'(d_wr_req_ready), 32'd1);
        check("sim_drd_ready", 32'(d_rd_req_ready), 32'd0);
        check("sim_ird_ready", 32'(i_rd_req_ready), 32'd0);
      end
    join
    check("sim_read_order", 32'(RR ? (acc_i < acc_d) : (acc_d < acc_i)), 32'd1);

    // Both reads pending again after a d-cache read was the last one served.
    fork
      do_read(1'b1, 32'h200, acc_d, nw);
      do_read(1'b0, 32'h300, acc_i, nw2);
    join
    check("pair_read_order", 32'(RR ? (acc_i < acc_d) : (acc_d < acc_i)), 32'd1);

    // Reset during beat 1 of an i-cache burst.
    i_rd_req_valid = 1'b1;
    i_rd_req_addr  = 26'h40;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      #3;
      if (i_rd_req_ready) begin
        got = 1'b1;
        push_line(1'b0, 32'h40);
      end
      @(posedge clk); #1;
    end
    i_rd_req_valid = 1'b0;
    check("rst_burst_accept", 32'(got), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("rst_burst_beat1_vld", 32'(i_rd_data_valid), 32'd1);
    rst_n = 1'b0;
    d_rd_req_valid = 1'b1;
    d_rd_req_addr  = 26'h48;
    #1;
    check("rst_burst_vld_drop", 32'(i_rd_data_valid), 32'd0);
    check("rst_burst_rdy_forced", 32'(d_rd_req_ready), 32'd0);
    check("rst_burst_beats_left", 32'(exp_i.size()), 32'd3);
    exp_i.delete();
    d_rd_req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(1'b1, 32'h48, acc_d, nw);
    check("post_rst_first_cycle_accept", 32'(nw), 32'd0);

    // Continuous i-cache requests: acceptances spaced RL+LW cycles apart.
    i_rd_req_valid = 1'b1;
    i_rd_req_addr  = 26'h200;
    n_acc = 0;
    for (int c = 0; c < 60 && n_acc < 3; c++) begin
      #3;
      if (i_rd_req_ready) begin
        t[n_acc] = cyc;
        n_acc++;
        push_line(1'b0, 32'h200);
      end
      @(posedge clk); #1;
    end
    i_rd_req_valid = 1'b0;
    check("b2b_count", 32'(n_acc), 32'd3);
    check("b2b_gap1", 32'(t[1] - t[0]), 32'd8);
    check("b2b_gap2", 32'(t[2] - t[1]), 32'd8);
    repeat (12) @(posedge clk);
    #1;
    check("i_queue_drained", 32'(exp_i.size()), 32'd0);
    check("d_queue_drained", 32'(exp_d.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
